// File: rtl/fir_sweep_pkg.sv
// fir_sweep_pkg: shared state encoding and sizing helper for the FIR frequency sweeper
package fir_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        STORE,
        DONE
    } sweep_state_t;

    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peak_abs_tracker.sv
// peak_abs_tracker: running maximum of saturated |sample|, clearable
module peak_abs_tracker #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     update,
    input  logic signed [DATA_W-1:0] sample,
    output logic        [DATA_W-1:0] peak
);

    localparam logic signed [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic        [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    // Most-negative input has no positive twin, so it clamps to the largest positive.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        return x == S_MIN ? POS_MAX : (x[DATA_W-1] ? -x : x);
    endfunction

    logic [DATA_W-1:0] mag;

    assign mag = abs_sat(sample);

    always_ff @(posedge clk) begin
        if (reset)
            peak <= '0;
        else
            peak <= clear ? '0 : (update && mag > peak) ? mag : peak;
    end

endmodule

// File: rtl/fir_sweep_analyzer.sv
// fir_sweep_analyzer: steps sine FCW across points, records peak |FIR output| per point
module fir_sweep_analyzer
    import fir_sweep_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int FCW_W          = 16,
    parameter int NUM_POINTS     = 16,
    parameter int SETTLE_PERIODS = 4,
    parameter int MEAS_PERIODS   = 2,
    parameter int ADDR_W         = $clog2(NUM_POINTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic        [FCW_W-1:0]  fcw_start,
    input  logic        [FCW_W-1:0]  fcw_step,
    output logic                     gen_enable,
    output logic        [FCW_W-1:0]  fcw,
    input  logic                     phase_wrap,
    input  logic signed [DATA_W-1:0] sample,
    output logic                     busy,
    output logic                     done,
    input  logic        [ADDR_W-1:0] rd_addr,
    output logic        [DATA_W-1:0] rd_data
);

    localparam int                 MAXP        = SETTLE_PERIODS > MEAS_PERIODS ? SETTLE_PERIODS : MEAS_PERIODS;
    localparam int                 CNT_W       = cnt_w(MAXP);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_PERIODS - 1);
    localparam logic [CNT_W-1:0]   MEAS_LAST   = CNT_W'(MEAS_PERIODS - 1);
    localparam logic [ADDR_W-1:0]  LAST_PT     = ADDR_W'(NUM_POINTS - 1);
    localparam logic [ADDR_W:0]    NP          = (ADDR_W + 1)'(NUM_POINTS);

    sweep_state_t      state, state_n;
    logic [ADDR_W-1:0] point;
    logic [CNT_W-1:0]  cnt;
    logic [FCW_W-1:0]  step_r;
    logic [DATA_W-1:0] peak;
    logic [DATA_W-1:0] mem [NUM_POINTS];
    logic              clear, update, store_en, last_pt, settle_end, meas_end;

    assign last_pt    = point == LAST_PT;
    assign settle_end = phase_wrap && cnt == SETTLE_LAST;
    assign meas_end   = phase_wrap && cnt == MEAS_LAST;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        busy       = state != IDLE;
        gen_enable = state == SETTLE || state == MEASURE || state == STORE;
        done       = state == DONE;
        clear      = state == SETTLE && settle_end;
        update     = state == MEASURE;
        store_en   = state == STORE;
        case (state)
            IDLE:    state_n = start ? SETTLE : IDLE;
            SETTLE:  state_n = settle_end ? MEASURE : SETTLE;
            MEASURE: state_n = meas_end ? STORE : MEASURE;
            STORE:   state_n = last_pt ? DONE : SETTLE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            point  <= '0;
            fcw    <= '0;
            step_r <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && start) begin
                point  <= '0;
                fcw    <= fcw_start;
                step_r <= fcw_step;
            end
            if (store_en && !last_pt) begin
                point <= point + 1'b1;
                fcw   <= fcw + step_r;
            end
            if (state == IDLE || store_en)
                cnt <= '0;
            else if (state == SETTLE && phase_wrap)
                cnt <= settle_end ? '0 : cnt + 1'b1;
            else if (state == MEASURE && phase_wrap)
                cnt <= meas_end ? '0 : cnt + 1'b1;
        end
    end

    peak_abs_tracker #(.DATA_W(DATA_W)) u_peak (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .update (update),
        .sample (sample),
        .peak   (peak)
    );

    // Result buffer is deliberately unreset so earlier sweeps survive a reset.
    always_ff @(posedge clk) begin
        if (store_en && !reset)
            mem[point] <= peak;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= {1'b0, rd_addr} < NP ? mem[rd_addr] : '0;
    end

endmodule

// File: tb/tb_fir_sweep_analyzer.sv
// tb_fir_sweep_analyzer: directed table-driven sweeps with hand-computed peaks
module tb_fir_sweep_analyzer;

    logic               clk = 0;
    logic               reset;
    logic               start;
    logic        [15:0] fcw_start, fcw_step;
    logic               gen_enable;
    logic        [15:0] fcw;
    logic               phase_wrap;
    logic signed [15:0] sample;
    logic               busy, done;
    logic        [1:0]  rd_addr;
    logic        [15:0] rd_data;

    fir_sweep_analyzer #(
        .DATA_W(16), .FCW_W(16), .NUM_POINTS(4), .SETTLE_PERIODS(2), .MEAS_PERIODS(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .fcw_start(fcw_start), .fcw_step(fcw_step),
        .gen_enable(gen_enable), .fcw(fcw), .phase_wrap(phase_wrap), .sample(sample),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] s_set;
        logic signed [15:0] m_a;
        logic signed [15:0] m_b;
        logic signed [15:0] m_last;
        logic        [15:0] exp;
    } pt_t;

    pt_t         vec [8];
    logic [15:0] model_mem [4];
    logic        known [4];
    int          total = 0;
    int          passed = 0;
    int          done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic pw, input logic signed [15:0] s);
        phase_wrap = pw;
        sample     = s;
        @(posedge clk);
        #1;
        if (done)
            done_seen++;
    endtask

    task automatic rd(input int a);
        rd_addr = 2'(a);
        step(0, 0);
        chk($sformatf("rd_mem%0d", a), rd_data, model_mem[a]);
    endtask

    task automatic run_sweep(input int base, input logic [15:0] fs, input logic [15:0] st, input int abort_pt);
        logic [15:0] exp_fcw;
        done_seen = 0;
        fcw_start = fs;
        fcw_step  = st;
        start     = 1;
        step(0, 0);
        start     = 0;
        fcw_start = 16'hAAAA;
        fcw_step  = 16'h5555;
        exp_fcw   = fs;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("fcw_pt%0d", p), fcw, exp_fcw);
            chk($sformatf("busy_pt%0d", p), busy, 1);
            chk($sformatf("gen_en_pt%0d", p), gen_enable, 1);
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 8; c++) begin
                    if (p == 1 && k == 0 && c == 0) begin
                        start     = 1;
                        fcw_start = 16'h1234;
                    end
                    step(c == 7, vec[base+p].s_set);
                    start = 0;
                end
            if (p == abort_pt) begin
                for (int c = 0; c < 3; c++)
                    step(0, vec[base+p].m_a);
                reset = 1;
                step(0, 0);
                reset = 0;
                chk("abort_gen_en", gen_enable, 0);
                chk("abort_busy", busy, 0);
                chk("abort_fcw", fcw, 0);
                chk("abort_done", done, 0);
                chk("abort_rd_data", rd_data, 0);
                return;
            end
            for (int c = 0; c < 8; c++)
                step(c == 7, c == 7 ? vec[base+p].m_last : (c % 2 == 1 ? vec[base+p].m_b : vec[base+p].m_a));
            rd_addr = 2'(p);
            step(0, 0);
            if (known[p])
                chk($sformatf("rd_during_store%0d", p), rd_data, model_mem[p]);
            model_mem[p] = vec[base+p].exp;
            known[p]     = 1;
            exp_fcw      = exp_fcw + st;
        end
        chk("done_pulse", done, 1);
        chk("done_gen_en", gen_enable, 0);
        chk("done_busy", busy, 1);
        step(0, 0);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("done_count", done_seen, 1);
    endtask

    initial begin
        vec[0] = '{16'sd0,     16'sd1000,   -16'sd500,  16'sd0,    16'd1000};
        vec[1] = '{16'sd0,     16'sd2000,   -16'sd2000, 16'sd0,    16'd2000};
        vec[2] = '{16'sd0,     -16'sd3000,  16'sd100,   16'sd0,    16'd3000};
        vec[3] = '{16'sd0,     16'sd4000,   16'sd0,     16'sd0,    16'd4000};
        vec[4] = '{16'sd0,     -16'sd20000, 16'sd15000, 16'sd0,    16'd20000};
        vec[5] = '{16'sd0,     16'sh8000,   16'sd0,     16'sd0,    16'd32767};
        vec[6] = '{16'sd30000, 16'sd1000,   -16'sd1000, 16'sd0,    16'd1000};
        vec[7] = '{16'sd0,     16'sd0,      16'sd0,     16'sd1500, 16'd1500};
        for (int i = 0; i < 4; i++) begin
            known[i]     = 0;
            model_mem[i] = '0;
        end
        reset      = 1;
        start      = 0;
        fcw_start  = 0;
        fcw_step   = 0;
        phase_wrap = 0;
        sample     = 0;
        rd_addr    = 0;
        repeat (3) step(0, 0);
        chk("rst_gen_en", gen_enable, 0);
        chk("rst_fcw", fcw, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 0;
        step(0, 0);
        chk("idle_busy", busy, 0);

        run_sweep(0, 16'h0100, 16'h0100, -1);
        for (int a = 0; a < 4; a++) rd(a);

        run_sweep(4, 16'hFF00, 16'h0200, -1);
        for (int a = 0; a < 4; a++) rd(a);

        run_sweep(0, 16'h0100, 16'h0100, 2);
        for (int a = 0; a < 4; a++) rd(a);

        run_sweep(0, 16'h0100, 16'h0100, -1);
        for (int a = 0; a < 4; a++) rd(a);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
